// File: rtl/beehive_bus_compare_pipe_if.sv
// Request/response handshake bundle for the pipelined masked bus comparator.
// The master side issues compares and consumes results; the slave side is the comparator.
interface beehive_bus_compare_pipe_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 8
);
  logic             src_cmp_val;
  logic [WIDTH-1:0] src_cmp_a;
  logic [WIDTH-1:0] src_cmp_b;
  logic [WIDTH-1:0] src_cmp_mask;
  logic [1:0]       src_cmp_op;
  logic [TAG_W-1:0] src_cmp_tag;
  logic             cmp_src_rdy;
  logic             cmp_dst_val;
  logic             cmp_dst_result;
  logic [TAG_W-1:0] cmp_dst_tag;
  logic             dst_cmp_rdy;

  modport master (
    output src_cmp_val, src_cmp_a, src_cmp_b, src_cmp_mask, src_cmp_op, src_cmp_tag,
    output dst_cmp_rdy,
    input  cmp_src_rdy, cmp_dst_val, cmp_dst_result, cmp_dst_tag
  );

  modport slave (
    input  src_cmp_val, src_cmp_a, src_cmp_b, src_cmp_mask, src_cmp_op, src_cmp_tag,
    input  dst_cmp_rdy,
    output cmp_src_rdy, cmp_dst_val, cmp_dst_result, cmp_dst_tag
  );
endinterface

// File: rtl/beehive_bus_compare_pipe.sv
// Two-stage masked bus comparator (EQ/NE/LTU/GEU) with valid/ready flow control,
// tag pass-through and a saturating count of true results.
module beehive_bus_compare_pipe #(
  parameter int WIDTH   = 64,
  parameter int CHUNK_W = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  beehive_bus_compare_pipe_if.slave   cmp,
  input  logic                        stat_clr,
  output logic [CNT_W-1:0]            match_count
);

  localparam int NCHUNK = WIDTH / CHUNK_W;

  if ((WIDTH % CHUNK_W) != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of CHUNK_W");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [WIDTH-1:0]  a_m, b_m, diff;
  logic [NCHUNK-1:0] eq_c, lt_c;

  logic              vld_p1;
  logic [NCHUNK-1:0] eq_p1, lt_p1;
  logic [1:0]        op_p1;
  logic [TAG_W-1:0]  tag_p1;

  logic              vld_p2;
  logic              res_p2;
  logic [TAG_W-1:0]  tag_p2;

  logic s1_adv, s2_adv;
  logic eq_all, lt_all, res_c;

  assign s2_adv = !vld_p2 || cmp.dst_cmp_rdy;
  assign s1_adv = !vld_p1 || s2_adv;

  assign cmp.cmp_src_rdy    = s1_adv;
  assign cmp.cmp_dst_val    = vld_p2;
  assign cmp.cmp_dst_result = res_p2;
  assign cmp.cmp_dst_tag    = tag_p2;

  assign a_m  = cmp.src_cmp_a & cmp.src_cmp_mask;
  assign b_m  = cmp.src_cmp_b & cmp.src_cmp_mask;
  assign diff = a_m ^ b_m;

  always_comb begin
    eq_c = '0;
    lt_c = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      eq_c[i] = (diff[i*CHUNK_W +: CHUNK_W] == '0);
      lt_c[i] = (a_m[i*CHUNK_W +: CHUNK_W] < b_m[i*CHUNK_W +: CHUNK_W]);
    end
  end

  // ---- stage 1 -> stage 2 boundary: per-chunk partials into a single verdict
  always_comb begin
    eq_all = &eq_p1;
    lt_all = 1'b0;
    // Later (higher) chunks overwrite, so the most significant differing chunk decides.
    for (int i = 0; i < NCHUNK; i++) begin
      if (!eq_p1[i]) lt_all = lt_p1[i];
    end
    unique case (op_p1)
      2'd0:    res_c = eq_all;
      2'd1:    res_c = !eq_all;
      2'd2:    res_c = lt_all;
      default: res_c = !lt_all;
    endcase
  end

  always_ff @(posedge clk) begin
    if (s1_adv && cmp.src_cmp_val) begin
      eq_p1  <= eq_c;
      lt_p1  <= lt_c;
      op_p1  <= cmp.src_cmp_op;
      tag_p1 <= cmp.src_cmp_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      res_p2      <= 1'b0;
      tag_p2      <= '0;
      match_count <= '0;
    end else begin
      if (s1_adv) vld_p1 <= cmp.src_cmp_val;
      if (s2_adv) vld_p2 <= vld_p1;
      if (s2_adv && vld_p1) begin
        res_p2 <= res_c;
        tag_p2 <= tag_p1;
      end
      if (stat_clr)
        match_count <= '0;
      else if (vld_p2 && cmp.dst_cmp_rdy && res_p2)
        match_count <= sat_inc(match_count);
    end
  end

endmodule

// File: doc/beehive_bus_compare_pipe.md
Name: beehive_bus_compare_pipe

Overview:
Pipelined, parametrised successor to the single-cycle bus equality comparator. Compares two WIDTH-bit buses under a bit mask, using one of four runtime-selectable operations (EQ, NE, unsigned LT, unsigned GE). The compare is split into CHUNK_W slices so wide buses (up to 512 bits) close timing. Uses valid/ready handshakes on both sides, carries a tag through the pipeline, and keeps a saturating count of true results. Sits in front of NoC header-match and tuple-lookup logic.

Parameters:
WIDTH, 64, compared bus width in bits; must be a multiple of CHUNK_W.
CHUNK_W, 16, slice width for the stage-1 partial compares.
TAG_W, 8, width of the opaque tag carried alongside each compare.
CNT_W, 16, width of the saturating match counter.

Ports:
clk  in  1  clock; all state is on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
src_cmp_val  in  1  input request valid.
src_cmp_a  in  WIDTH  operand A.
src_cmp_b  in  WIDTH  operand B.
src_cmp_mask  in  WIDTH  1 = bit participates in the compare; 0 = bit forced equal.
src_cmp_op  in  2  0=EQ, 1=NE, 2=LTU (A<B), 3=GEU (A>=B).
src_cmp_tag  in  TAG_W  opaque tag, returned with the result.
cmp_src_rdy  out  1  block can accept a request this cycle.
cmp_dst_val  out  1  result valid.
cmp_dst_result  out  1  compare outcome.
cmp_dst_tag  out  TAG_W  tag of the request that produced this result.
dst_cmp_rdy  in  1  consumer accepts the result.
stat_clr  in  1  synchronous clear of match_count.
match_count  out  CNT_W  number of handshaked results equal to 1; saturating.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Elaboration check: if WIDTH % CHUNK_W != 0, elaboration fails with $error. NCHUNK = WIDTH/CHUNK_W.
- Reset values: cmp_dst_val=0, cmp_dst_result=0, cmp_dst_tag=0, match_count=0. All internal valid bits are 0.
- Reset mid-operation: in-flight requests are discarded. Nothing is emitted after reset deasserts until a new request is accepted.
- Input handshake: a request is accepted when src_cmp_val && cmp_src_rdy.
- Stage 1 (registered), per chunk i:
  - eq[i] = ((A^B)&M) slice i == 0.
  - lt[i] = (A&M) slice i < (B&M) slice i, unsigned.
  - op and tag are registered alongside; s1_val is set.
- Stage 2 (registered):
  - EQ = AND of all eq[i].
  - LT = lt[] of the most-significant chunk whose eq[] is 0; LT=0 if every chunk is equal.
  - result: op0 EQ, op1 !EQ, op2 LT, op3 !LT.
  - Results land in cmp_dst_result and cmp_dst_tag, and cmp_dst_val is set.
- Flow control:
  - s2_adv = !cmp_dst_val || dst_cmp_rdy.
  - s1_adv = !s1_val || s2_adv.
  - cmp_src_rdy = s1_adv. This is combinational from dst_cmp_rdy; there is no skid buffer.
- Latency and throughput: a request accepted at edge N presents its result from cycle N+2 when there are no stalls. Throughput is 1 per cycle. Stalls backpressure without loss or reordering.
- Output hold: while cmp_dst_val && !dst_cmp_rdy, cmp_dst_result and cmp_dst_tag are held stable.
- Bubbles: when stage 1 is empty and stage 2 advances, cmp_dst_val drops to 0 the next cycle. Bubbles collapse.
- match_count:
  - Increments by 1 on each output handshake (cmp_dst_val && dst_cmp_rdy) with cmp_dst_result=1.
  - Saturates at 2^CNT_W-1; no wrap-around.
  - stat_clr sets it to 0 and takes priority over a simultaneous increment in the same cycle.
- All-zero mask: EQ=1 and LT=0, so EQ and GEU return 1.
- Width rule: the compare is unsigned only. Mask is applied to both operands before LT.

Test Plan:
- Basic EQ/NE: WIDTH=64, A=B=64'hDEAD_BEEF_0000_1234, M=all ones. Op EQ gives result=1, op NE gives result=0. Each result appears 2 cycles after acceptance with its tag returned.
- Masked compare: A=64'h00FF, B=64'h0000, M=64'hFF00, op EQ -> 1. Same operands with M=all ones -> 0.
- Cross-chunk LTU/GEU: A=64'h0001_0000_0000_FFFF, B=64'h0001_0000_0001_0000. LTU -> 1 and GEU -> 0, decided by chunk 1 despite chunk 0 having A>B. Swapping A and B gives LTU -> 0.
- Backpressure: stream 8 back-to-back requests with tags 0..7 while dst_cmp_rdy is low for cycles 3-6. cmp_src_rdy drops within the stall and no tag is lost or reordered. Output tags are 0..7 in order, and results stay stable while stalled.
- Counter: with CNT_W=4, feed 20 EQ-true results and check match_count saturates at 15. Assert stat_clr in the same cycle as a true handshake; the next match_count is 0.
- Reset mid-stream: deassert rst_n with 2 requests in flight. cmp_dst_val=0 immediately (asynchronously) and match_count=0. After release, no stale result is emitted and the next request returns correctly in 2 cycles.
